// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - assembles SYNC/LEN/payload/CSUM frames from UART receiver bytes
module uart_frame_parser #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 130210
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         frame_avail,
    output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
    output logic [7:0]                   rd_data,
    input  logic                         frame_ack,
    output logic                         err_csum,
    output logic                         err_len,
    output logic                         err_timeout,
    output logic                         err_overrun
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CLKS - 1);
    localparam logic [LW-1:0] LEN_ONE   = LW'(1);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          frame_avail_q, frame_avail_d;
    logic [LW-1:0] frame_len_q, frame_len_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          err_csum_q, err_csum_d;
    logic          err_len_q, err_len_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_overrun_q, err_overrun_d;
    logic          buf_we;
    logic [7:0]    buf_q [2**AW];

    logic          in_frame, expired, csum_ok, len_ok, last_pay;
    logic [7:0]    csum_total;

    assign in_frame   = state_q inside {S_LEN, S_PAYLOAD, S_CSUM};
    // A byte on the expiry cycle keeps the frame alive, so expiry requires an idle cycle.
    assign expired    = in_frame && !byte_valid && (cnt_q == T_LAST);
    assign csum_total = sum_q + byte_data;
    assign csum_ok    = (csum_total == 8'h00);
    assign len_ok     = (byte_data != 8'h00) && (byte_data <= MAX_LEN_B);
    assign last_pay   = ((LW'(idx_q) + LEN_ONE) == len_q);
    assign rd_data_d  = buf_q[rd_addr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_HUNT;
            len_q         <= '0;
            sum_q         <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            frame_avail_q <= 1'b0;
            frame_len_q   <= '0;
            rd_data_q     <= '0;
            err_csum_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            sum_q         <= sum_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            frame_avail_q <= frame_avail_d;
            frame_len_q   <= frame_len_d;
            rd_data_q     <= rd_data_d;
            err_csum_q    <= err_csum_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[idx_q] <= byte_data;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        cnt_d   = (in_frame && !byte_valid) ? (cnt_q + TW'(1)) : '0;
        if (expired) begin
            state_d = S_HUNT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (byte_valid && (byte_data == SYNC_BYTE)) begin
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (byte_valid) begin
                        if (len_ok) begin
                            len_d   = byte_data[LW-1:0];
                            sum_d   = byte_data;
                            idx_d   = '0;
                            state_d = S_PAYLOAD;
                        end else begin
                            state_d = S_HUNT;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (byte_valid) begin
                        sum_d = sum_q + byte_data;
                        idx_d = idx_q + AW'(1);
                        if (last_pay) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (byte_valid) begin
                        state_d = csum_ok ? S_HOLD : S_HUNT;
                    end
                end
                S_HOLD: begin
                    if (frame_ack) begin
                        state_d = S_HUNT;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    always_comb begin
        err_csum_d    = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = expired;
        err_overrun_d = 1'b0;
        frame_avail_d = frame_avail_q;
        frame_len_d   = frame_len_q;
        buf_we        = 1'b0;
        case (state_q)
            S_LEN:     err_len_d = byte_valid && !len_ok;
            S_PAYLOAD: buf_we    = byte_valid;
            S_CSUM: begin
                if (byte_valid) begin
                    if (csum_ok) begin
                        frame_avail_d = 1'b1;
                        frame_len_d   = len_q;
                    end else begin
                        err_csum_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                err_overrun_d = byte_valid;
                if (frame_ack) begin
                    frame_avail_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign frame_avail = frame_avail_q;
    assign frame_len   = frame_len_q;
    assign rd_data     = rd_data_q;
    assign err_csum    = err_csum_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - table-driven frames with an event scoreboard for uart_frame_parser
module tb_uart_frame_parser;

    localparam int MAXL = 16;
    localparam int TO   = 40;
    localparam int EV_OK = 0, EV_CSUM = 1, EV_LEN = 2, EV_TO = 3, EV_OVR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic [3:0] rd_addr = 4'h0;
    logic       frame_ack = 1'b0;
    logic       frame_avail;
    logic [4:0] frame_len;
    logic [7:0] rd_data;
    logic       err_csum, err_len, err_timeout, err_overrun;

    int         total = 0;
    int         bad = 0;
    int         exp_q[$];
    bit         avail_prev = 1'b0;
    logic [7:0] pay [MAXL];

    typedef struct {
        logic [63:0] bytes;
        int          n;
        int          ev;
        int          len;
    } vec_t;
    vec_t tbl [9];

    always #4 clk = ~clk;

    uart_frame_parser #(.MAX_LEN(MAXL), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .frame_avail(frame_avail), .frame_len(frame_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_ack(frame_ack), .err_csum(err_csum),
        .err_len(err_len), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Every error pulse and every rising frame_avail must match the next expected event.
    always @(negedge clk) begin
        int cnt;
        int ev;
        cnt = int'(err_csum) + int'(err_len) + int'(err_timeout) + int'(err_overrun)
            + int'(frame_avail && !avail_prev);
        if (cnt > 1) chk("one_event_per_cycle", cnt, 1);
        if (cnt > 0) begin
            ev = err_csum ? EV_CSUM : err_len ? EV_LEN : err_timeout ? EV_TO :
                 err_overrun ? EV_OVR : EV_OK;
            if (exp_q.size() == 0) chk("unexpected_event", ev, 32'hFFFF);
            else                   chk("event", ev, exp_q.pop_front());
        end
        avail_prev = frame_avail;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic read_check(input int len);
        for (int i = 0; i < len; i++) begin
            rd_addr = 4'(i);
            tick();
            chk("rd_data", rd_data, pay[i]);
        end
    endtask

    task automatic ack_check();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("avail_after_ack", frame_avail, 0);
    endtask

    task automatic send_vec(input int i);
        exp_q.push_back(tbl[i].ev);
        for (int k = 0; k < tbl[i].n; k++) send(tbl[i].bytes[63-8*k -: 8]);
        for (int j = 0; j < tbl[i].len; j++)
            pay[j] = tbl[i].bytes[63-8*(tbl[i].n-1-tbl[i].len+j) -: 8];
    endtask

    task automatic run_vec(input int i);
        send_vec(i);
        if (tbl[i].ev == EV_OK) begin
            chk("frame_avail", frame_avail, 1);
            chk("frame_len", frame_len, tbl[i].len);
            read_check(tbl[i].len);
            ack_check();
        end else begin
            tick();
            chk("no_frame_on_error", frame_avail, 0);
        end
        drain("vec_events");
    endtask

    initial begin
        logic [7:0] s;
        int seen;
        #5000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
        s = 0; seen = 0;
    end

    initial begin
        logic [7:0] s;
        int seen;
        tbl[0] = '{64'hA5_03_10_20_30_9D_00_00, 6, EV_OK,   3};
        tbl[1] = '{64'hA5_02_01_02_00_00_00_00, 5, EV_CSUM, 0};
        tbl[2] = '{64'hA5_01_FF_00_00_00_00_00, 4, EV_OK,   1};
        tbl[3] = '{64'hA5_00_00_00_00_00_00_00, 2, EV_LEN,  0};
        tbl[4] = '{64'hA5_11_00_00_00_00_00_00, 2, EV_LEN,  0};
        tbl[5] = '{64'hA5_A5_00_00_00_00_00_00, 2, EV_LEN,  0};
        tbl[6] = '{64'h00_FF_A5_02_AA_BB_99_00, 7, EV_OK,   2};
        tbl[7] = '{64'hA5_02_00_00_FE_00_00_00, 5, EV_OK,   2};
        tbl[8] = '{64'hA5_01_00_00_00_00_00_00, 4, EV_CSUM, 0};

        rst = 1'b0;
        repeat (3) tick();
        chk("rst_frame_avail", frame_avail, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_err_csum", err_csum, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_err_overrun", err_overrun, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(i);

        // Maximum-length frame
        exp_q.push_back(EV_OK);
        send(8'hA5);
        send(8'h10);
        s = 8'h10;
        for (int i = 0; i < MAXL; i++) begin
            pay[i] = 8'(i * 17 + 3);
            s = s + pay[i];
            send(pay[i]);
        end
        send(8'h00 - s);
        chk("max_frame_avail", frame_avail, 1);
        chk("max_frame_len", frame_len, MAXL);
        read_check(MAXL);
        ack_check();
        drain("max_events");

        // Timeout fires on the TO-th idle cycle after the last byte
        exp_q.push_back(EV_TO);
        send(8'hA5); send(8'h02); send(8'hAA);
        seen = -1;
        for (int k = 1; k <= TO + 3; k++) begin
            tick();
            if (err_timeout && seen < 0) seen = k;
        end
        chk("timeout_cycle", seen, TO);
        drain("timeout_events");
        run_vec(2);

        // Byte arriving on the expiry cycle keeps the frame alive
        exp_q.push_back(EV_OK);
        send(8'hA5); send(8'h02); send(8'hAA);
        repeat (TO - 1) tick();
        send(8'hBB);
        send(8'h99);
        pay[0] = 8'hAA; pay[1] = 8'hBB;
        chk("keepalive_avail", frame_avail, 1);
        chk("keepalive_len", frame_len, 2);
        read_check(2);
        ack_check();
        drain("keepalive_events");

        // Overrun while holding; long hold must not time out
        send_vec(0);
        repeat (2 * TO) tick();
        exp_q.push_back(EV_OVR); exp_q.push_back(EV_OVR); exp_q.push_back(EV_OVR);
        send(8'h11); send(8'h22); send(8'h33);
        tick();
        chk("overrun_hold_avail", frame_avail, 1);
        chk("overrun_hold_len", frame_len, 3);
        read_check(3);
        exp_q.push_back(EV_OVR);
        frame_ack = 1'b1; byte_valid = 1'b1; byte_data = 8'hA5;
        tick();
        frame_ack = 1'b0; byte_valid = 1'b0;
        chk("ack_with_byte_avail", frame_avail, 0);
        run_vec(2);

        // Reset in HOLD, then reset during PAYLOAD
        send_vec(0);
        drain("pre_reset_events");
        rst = 1'b0;
        tick();
        chk("rst_hold_avail", frame_avail, 0);
        chk("rst_hold_len", frame_len, 0);
        chk("rst_hold_rd_data", rd_data, 0);
        rst = 1'b1;
        send(8'hA5); send(8'h03); send(8'h10);
        rst = 1'b0;
        tick();
        chk("rst_pay_avail", frame_avail, 0);
        chk("rst_pay_errs", {err_csum, err_len, err_timeout, err_overrun}, 0);
        rst = 1'b1;
        send(8'h20); send(8'h30); send(8'h9D);
        repeat (3) tick();
        chk("tail_ignored_avail", frame_avail, 0);
        run_vec(6);

        repeat (4) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
